// File: rtl/vga_config_if.sv
// Decoded register-write bus between address_decoder (master) and vga_config_ctrl (slave).
interface vga_config_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ack;

  modport master (output address, data, valid, input ack);
  modport slave  (input address, data, valid, output ack);
endinterface

// File: rtl/vga_config_ctrl.sv
// Shadow/active configuration bank for the VGA datapath with immediate or vsync-deferred commit.
// Optional readback port enabled by defining CFG_READBACK_EN.
//
// state  | meaning
// S_IDLE | waiting for a valid rise
// S_ACK  | ack driven for the transaction opened at the previous edge
module vga_config_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  vga_config_if.slave                      bus,
  input  logic                             vsync_start_i,
  output logic [(NUM_REGS-1)*DATA_W-1:0]   cfg_active_o,
  output logic                             cfg_update_o,
  output logic                             busy_o,
  output logic                             err_o
`ifdef CFG_READBACK_EN
  ,
  input  logic [ADDR_W-1:0]                rd_addr_i,
  output logic [DATA_W-1:0]                rd_data_o
`endif
);
  localparam int NSLOT  = NUM_REGS - 1;
  localparam int BANK_W = NSLOT * DATA_W;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NSLOT);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t              state_q, state_d;
  logic                valid_q, rise, is_ctrl, is_oor;
  logic                discard, imm_set, defer_set, load;
  logic                imm_q, imm_d, pending_q, pending_d, err_q, err_d, upd_q;
  logic [BANK_W-1:0]   shadow_q, shadow_d, active_q, active_d;

  assign rise      = bus.valid & ~valid_q;
  assign is_ctrl   = (bus.address == CTRL_ADDR);
  assign is_oor    = (32'(bus.address) >= 32'(NUM_REGS));
  assign discard   = rise & is_ctrl & bus.data[2];
  assign imm_set   = rise & is_ctrl & bus.data[1] & ~bus.data[2];
  assign defer_set = rise & is_ctrl & bus.data[0] & ~bus.data[2];
  // Immediate and deferred commit on the same edge collapse into one load.
  assign load      = imm_q | (vsync_start_i & pending_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rise) state_d = S_ACK;
      S_ACK:   state_d = rise ? S_ACK : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ack = (state_q == S_ACK);
  end

  always_comb begin
    shadow_d = shadow_q;
    active_d = load ? shadow_q : active_q;
    if (rise && !is_ctrl && !is_oor) begin
      for (int i = 0; i < NSLOT; i++)
        if (bus.address == ADDR_W'(i)) shadow_d[i*DATA_W +: DATA_W] = bus.data;
    end
    if (discard) shadow_d = active_q;
    pending_d = load ? 1'b0 : pending_q;
    if (discard)        pending_d = 1'b0;
    else if (defer_set) pending_d = 1'b1;
    imm_d = imm_set;
    err_d = rise & (is_oor | (is_ctrl & bus.data[3]));
  end

  // valid_q resets high so a valid held through reset is not seen as a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b1;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      imm_q     <= 1'b0;
      err_q     <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      valid_q   <= bus.valid;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      imm_q     <= imm_d;
      err_q     <= err_d;
      upd_q     <= load;
    end
  end

  assign cfg_active_o = active_q;
  assign cfg_update_o = upd_q;
  assign busy_o       = pending_q;
  assign err_o        = err_q;

`ifdef CFG_READBACK_EN
  logic [DATA_W-1:0] rd_q, rd_d;

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NSLOT; i++)
      if (rd_addr_i == ADDR_W'(i)) rd_d = shadow_q[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end

  assign rd_data_o = rd_q;
`endif
endmodule
